// File: rtl/rvvi_seq_pkg.sv
// Shared types and helpers for the RVVI retire sequencer.
// Default entry shape matches a 32-bit instruction and 64-bit PC.
package rvvi_seq_pkg;

    localparam int ENTRY_ILEN = 32;
    localparam int ENTRY_XLEN = 64;

    localparam logic [15:0] DROP_SAT = 16'hFFFF;

    typedef struct packed {
        logic [ENTRY_ILEN-1:0] insn;
        logic [ENTRY_XLEN-1:0] pc;
        logic                  trap;
    } retire_entry_t;

    function automatic int hart_w(input int nhart);
        return (nhart > 1) ? $clog2(nhart) : 1;
    endfunction

    function automatic int entry_w(input int ilen, input int xlen);
        return ilen + xlen + 1;
    endfunction

endpackage

// File: rtl/rvvi_hart_fifo.sv
// Per-hart show-ahead FIFO: up to RETIRE compacted writes per cycle, one read.
// A group that does not fit in the free space (sampled before the read) is dropped whole.
module rvvi_hart_fifo #(
    parameter  int RETIRE = 1,
    parameter  int DEPTH  = 16,
    parameter  int W      = 97,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [RETIRE-1:0]   i_wr_vld,
    input  logic [RETIRE*W-1:0] i_wr_dat,
    input  logic                i_rd_en,
    output logic [W-1:0]        o_rd_dat,
    output logic                o_empty,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_drop,
    output logic [CNT_W-1:0]    o_drop_n
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_free;
    logic [PTR_W-1:0] w_addr [RETIRE];
    logic             w_accept;

    // Each valid slot lands at write pointer + number of valid slots below it.
    always_comb begin
        w_n = '0;
        for (int r = 0; r < RETIRE; r++) begin
            w_addr[r] = r_wr_ptr + w_n[PTR_W-1:0];
            w_n       = w_n + CNT_W'(i_wr_vld[r]);
        end
    end

    assign w_free   = CNT_W'(DEPTH) - r_count;
    assign w_accept = (w_free >= w_n);
    assign o_drop   = !w_accept;
    assign o_drop_n = w_accept ? '0 : w_n;
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int r = 0; r < RETIRE; r++) begin
                if (i_wr_vld[r]) begin
                    r_mem[w_addr[r]] <= i_wr_dat[r*W +: W];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + w_n[PTR_W-1:0];
            end
            if (i_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + (w_accept ? w_n : '0) - CNT_W'(i_rd_en);
        end
    end

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// Serialises multi-hart, multi-slot RVVI retirements into one entry per cycle.
// Entries appear one cycle after capture; a stalled grant is frozen until accepted.
module rvvi_retire_sequencer
    import rvvi_seq_pkg::*;
#(
    parameter  int NHART  = 1,
    parameter  int RETIRE = 1,
    parameter  int XLEN   = 64,
    parameter  int ILEN   = 32,
    parameter  int DEPTH  = 16,
    localparam int HW     = hart_w(NHART)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NHART*RETIRE-1:0]       valid_i,
    input  logic [NHART*RETIRE*ILEN-1:0]  insn_i,
    input  logic [NHART*RETIRE*XLEN-1:0]  pc_i,
    input  logic [NHART*RETIRE-1:0]       trap_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [HW-1:0]                 out_hart,
    output logic [ILEN-1:0]               out_insn,
    output logic [XLEN-1:0]               out_pc,
    output logic                          out_trap,
    output logic [31:0]                   out_seq,
    output logic                          overflow,
    output logic [15:0]                   drop_count
);

    localparam int EW    = entry_w(ILEN, XLEN);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
    } entry_t;

    logic [RETIRE*EW-1:0] w_wr_dat  [NHART];
    logic [EW-1:0]        w_rd_dat  [NHART];
    logic [CNT_W-1:0]     w_count   [NHART];
    logic [CNT_W-1:0]     w_drop_n  [NHART];
    logic [NHART-1:0]     w_empty;
    logic [NHART-1:0]     w_drop;
    logic [NHART-1:0]     w_pop;
    logic [NHART-1:0]     w_busy;
    logic [HW-1:0]        w_grant;
    logic                 w_fire;
    entry_t               w_head;
    logic [31:0]          w_drop_sum;
    logic [31:0]          w_drop_next;

    logic [HW-1:0]        r_rr;
    logic                 r_hold;
    logic [HW-1:0]        r_hold_hart;
    logic [31:0]          r_seq;
    logic                 r_ovf;
    logic [15:0]          r_drop;

    always_comb begin
        for (int h = 0; h < NHART; h++) begin
            for (int r = 0; r < RETIRE; r++) begin
                w_wr_dat[h][r*EW +: EW] = {insn_i[(h*RETIRE+r)*ILEN +: ILEN],
                                           pc_i[(h*RETIRE+r)*XLEN +: XLEN],
                                           trap_i[h*RETIRE+r]};
            end
        end
    end

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        rvvi_hart_fifo #(
            .RETIRE (RETIRE),
            .DEPTH  (DEPTH),
            .W      (EW)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .i_wr_vld (valid_i[h*RETIRE +: RETIRE]),
            .i_wr_dat (w_wr_dat[h]),
            .i_rd_en  (w_pop[h]),
            .o_rd_dat (w_rd_dat[h]),
            .o_empty  (w_empty[h]),
            .o_count  (w_count[h]),
            .o_drop   (w_drop[h]),
            .o_drop_n (w_drop_n[h])
        );
        assign w_busy[h] = (w_count[h] != '0);
        assign w_pop[h]  = w_fire && (w_grant == HW'(h));
    end

    // Round-robin search from r_rr; a stalled grant overrides so the head cannot change.
    always_comb begin
        logic [HW-1:0] idx;
        logic          found;
        w_grant = r_rr;
        found   = 1'b0;
        for (int i = 0; i < NHART; i++) begin
            idx = HW'((int'(r_rr) + i) % NHART);
            if (!found && !w_empty[idx]) begin
                w_grant = idx;
                found   = 1'b1;
            end
        end
        if (r_hold) begin
            w_grant = r_hold_hart;
        end
    end

    always_comb begin
        w_drop_sum = '0;
        for (int h = 0; h < NHART; h++) begin
            w_drop_sum = w_drop_sum + 32'(w_drop_n[h]);
        end
        w_drop_next = 32'(r_drop) + w_drop_sum;
    end

    assign out_valid  = |w_busy;
    assign w_fire     = out_valid && out_ready;
    assign w_head     = entry_t'(w_rd_dat[w_grant]);
    assign out_hart   = w_grant;
    assign out_insn   = w_head.insn;
    assign out_pc     = w_head.pc;
    assign out_trap   = w_head.trap;
    assign out_seq    = r_seq;
    assign overflow   = r_ovf;
    assign drop_count = r_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr        <= '0;
            r_hold      <= 1'b0;
            r_hold_hart <= '0;
            r_seq       <= '0;
            r_ovf       <= 1'b0;
            r_drop      <= '0;
        end else begin
            r_hold      <= out_valid && !out_ready;
            r_hold_hart <= w_grant;
            if (w_fire) begin
                r_rr  <= HW'((int'(w_grant) + 1) % NHART);
                r_seq <= r_seq + 32'd1;
            end
            if (|w_drop) begin
                r_ovf <= 1'b1;
            end
            r_drop <= (w_drop_next > 32'(DROP_SAT)) ? DROP_SAT : w_drop_next[15:0];
        end
    end

endmodule

// File: doc/rvvi_retire_sequencer.md
Name: rvvi_retire_sequencer

Overview:
- Serializes retirement events from a multi-hart, multi-retire RVVI trace into one instruction-per-cycle stream for the coverage sampler and disassembler.
- Removes the single-hart, single-slot restriction in the coverage driver.
- Per-hart buffering preserves program order within each hart; a round-robin arbiter shares the sampler between harts.
- Sits between the rvviTrace interface signals and the coverage sample call.

Parameters:
- NHART, 1, number of harts.
- RETIRE, 1, maximum retirements per hart per cycle.
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- DEPTH, 16, entries per hart FIFO; power of two, and DEPTH >= RETIRE.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_i  in  NHART*RETIRE  retire valid; bit index h*RETIRE+r.
- insn_i  in  NHART*RETIRE*ILEN  retired instruction per slot.
- pc_i  in  NHART*RETIRE*XLEN  retired PC per slot.
- trap_i  in  NHART*RETIRE  slot trapped.
- out_valid  out  1  entry available.
- out_ready  in  1  sampler accepts the entry.
- out_hart  out  max(1,$clog2(NHART))  source hart.
- out_insn  out  ILEN  instruction.
- out_pc  out  XLEN  PC.
- out_trap  out  1  trap flag.
- out_seq  out  32  global emit index of the current entry.
- overflow  out  1  sticky; a retire group was dropped.
- drop_count  out  16  dropped instructions, saturating.

Behaviour:
- Reset: all FIFO pointers and counts 0, RR pointer 0, out_valid 0, out_seq 0, overflow 0, drop_count 0. Reset mid-operation discards all buffered entries with no output.
- Enqueue, per hart h each cycle:
  - n = popcount of valid_i[h*RETIRE +: RETIRE].
  - Valid slots are written in ascending slot index to consecutive FIFO locations; invalid slots are compacted out.
- Full check uses pre-dequeue occupancy:
  - If DEPTH - count_h < n, the whole group for hart h is dropped (no partial writes).
  - On a drop: overflow <= 1; drop_count += n, saturating at 16'hFFFF.
  - Other harts are unaffected.
- Latency: an entry enqueued at edge N is visible on the outputs in cycle N+1 at the earliest. No same-cycle bypass.
- Outputs: show-ahead from the granted hart's FIFO head, combinational from registered state.
  - out_valid = any FIFO non-empty.
  - out_* fields are don't-care when out_valid = 0.
- Arbitration:
  - Grant goes to the first non-empty hart, searching from rr_ptr upward with wrap-around.
  - The grant is held stable while out_valid && !out_ready; the granted entry must not change.
- Handshake out_valid && out_ready:
  - Pop the granted FIFO.
  - rr_ptr <= grant+1 mod NHART.
  - out_seq increments, wrapping at 2^32.
- Simultaneous enqueue and dequeue on the same hart: both take effect; count_h += n - 1.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1, so full (count = DEPTH) is distinguishable from empty.
- NHART=1, RETIRE=1: degenerates to a single FIFO with a one-cycle delay.

Decomposition:
- Package rvvi_seq_pkg:
  - typedef struct retire_entry_t {insn, pc, trap}, parameterized through localparams for ILEN/XLEN.
  - Width function for hart index.
  - DROP_SAT constant.
- Sub-module rvvi_hart_fifo: multi-write (up to RETIRE per cycle, compacted), single-read, show-ahead FIFO. Exposes count and empty.
- Top level: NHART FIFO instances, round-robin arbiter, output mux, out_seq counter, overflow and drop counter.

Test Plan:
- NHART=1, RETIRE=1, out_ready=1; valid pulses at cycles 2, 3, 4 with pc 0x80000000/4/8 -> out_valid at cycles 3, 4, 5 with the same PCs in order; out_seq 0, 1, 2.
- NHART=1, RETIRE=2; one cycle with both slots valid (pc 0x100, 0x104) -> emitted 0x100 then 0x104 on consecutive cycles; slot1-only cycle with pc 0x200 -> a single entry 0x200.
- NHART=2, both harts retire every cycle for 4 cycles, out_ready=1 -> outputs alternate hart 0,1,0,1…; per-hart PC order preserved; 8 entries total.
- DEPTH=4, out_ready=0, hart 0 retires 6 single instructions -> 4 buffered; overflow=1, drop_count=2; releasing out_ready emits exactly the first 4 PCs.
- out_ready toggled 1,0,0,1 during a 2-hart backlog -> out_hart/out_pc stable while stalled; rr_ptr advances only on handshake.
- reset asserted for 1 cycle with 3 entries buffered -> next cycle out_valid=0, out_seq=0, overflow=0; new retires emitted normally afterward.
